tensor_burst_controller: RTL
============================

// Module: tensor_burst_controller
// PURPOSE
//  Parametrised next-generation controller for the small tensor core: decodes 16-bit instructions, runs
//  burst writes of operand matrices into the register file, starts core operations, and streams results
//  out LANES elements per beat under valid/ready handshakes. Sits between the instruction port and the
//  tensor register file / tensor core. Adds backpressure, matrix2-only writes and a stable read snapshot.
// PARAMETERS
//  DATA_WIDTH  8  bits per matrix element (signed)
//  DIM         3  matrix is DIM x DIM; ELEMS = DIM*DIM
//  LANES       2  elements moved per beat; BEATS = ceil(ELEMS/LANES)
// PORTS
//  clock_in           in   1                  sole clock
//  reset_in           in   1                  synchronous, active-low reset
//  instr_valid_in     in   1                  instruction offered
//  instr_ready_out    out  1                  high only in IDLE; instruction accepted on valid&&ready
//  instr_in           in   16                 [1:0] opcode, [3:2] select
//  wr_valid_in        in   1                  write beat offered
//  wr_ready_out       out  1                  controller accepts write beat
//  wr_data_in         in   LANES*DATA_WIDTH   lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//  rd_valid_out       out  1                  read beat valid
//  rd_ready_in        in   1                  consumer accepts read beat
//  rd_data_out        out  LANES*DATA_WIDTH   result lanes; unused lanes of last beat = 0
//  rf_we_out          out  1                  register-file write strobe
//  rf_matrix_out      out  1                  0 = matrix1, 1 = matrix2
//  rf_index_out       out  $clog2(ELEMS)      element index of lane 0
//  rf_lane_mask_out   out  LANES              lane k writes only if bit k set
//  rf_data_out        out  LANES*DATA_WIDTH   copy of accepted wr_data_in
//  core_start_out     out  1                  one-cycle start pulse
//  core_op_out        out  2                  operation select (instr_in[3:2])
//  core_done_in       in   1                  core result valid pulse
//  core_result_in     in   ELEMS*DATA_WIDTH   element e at [e*DATA_WIDTH +: DATA_WIDTH], row-major
//  busy_out           out  1                  state != IDLE
//  error_out          out  1                  one-cycle pulse on reserved opcode
// BEHAVIOUR
//  Reset: all outputs 0 except instr_ready_out=1; state IDLE; counters 0. Reset mid-burst/operate aborts
//   at once; no further rf_we_out or rd_valid_out. Reset dominates every other event.
//  Opcodes: 00 NOP; 01 OPERATE; 10 BURST (select 00 READ, 01 WRITE, 10 READ_WRITE, 11 WRITE_M2);
//   11 reserved -> error_out pulse next cycle, state stays IDLE.
//  States: IDLE, OPERATE, BURST. OPERATE: core_start_out pulses the cycle after accept, core_op_out held;
//   wait for core_done_in, then IDLE next cycle. core_done_in seen in any other state is ignored.
//  BURST entry: beat counter 0; READ/READ_WRITE latch core_result_in into snapshot on accept cycle.
//  Write beat count: WRITE/READ_WRITE 2*BEATS (beats 0..BEATS-1 matrix1, then matrix2); WRITE_M2 BEATS.
//  Read beat count BEATS. READ_WRITE: read beat b paired with write beat b for b<BEATS; later beats
//   write-only. A paired beat advances only when wr_valid_in && rd_ready_in (both ready/valid asserted
//   together); no partial advance.
//  Write beat accepted -> registered rf_we_out next cycle with rf_index_out=(b mod BEATS)*LANES, mask
//   clears lanes with index >= ELEMS. Latency 1 cycle, one write per beat, no drops.
//  rd_valid_out/rd_data_out registered from snapshot; held stable while rd_valid_out && !rd_ready_in.
//  BURST returns to IDLE the cycle after the final beat handshake; instr_ready_out rises that cycle.
//  Instructions offered while busy are not accepted (held by source); no queueing.
//  Snapshot isolation: core_result_in changes during a read burst do not affect rd_data_out.
// STRUCTURE
//  Package tensor_controller_pkg: opcode/select localparams, state enum, BEATS/index-width functions.
//  One sub-module: tensor_result_snapshot (ELEMS-entry register + LANES-wide beat mux, zero padding).
//  Beat counter, FSM, write path and handshakes stay in this module.
// TESTING (DIM=3, LANES=2, BEATS=5)
//  WRITE, beats 1..10 with data {2b,2b-1} no stalls -> 10 rf writes, idx 0,2,4,6,8 m1 then m2, last mask 01.
//  WRITE_M2 with wr_valid_in toggling every cycle -> 5 writes all rf_matrix_out=1, 9 cycles later idle.
//  core_result_in = 1..9, READ, rd_ready_in low 3 cycles on beat 2 -> beats {1,2},{3,4},{5,6}... {9,0},
//   data stable through stall; result input changed mid-burst has no effect.
//  OPERATE op=2, core_done_in after 7 cycles -> one start pulse, busy 8 cycles, instr_ready_out 0 meanwhile.
//  Opcode 11 -> error_out one pulse, busy_out stays 0; reset_in low during beat 3 of READ_WRITE -> idle next edge.
//  READ_WRITE: wr_valid_in high, rd_ready_in low -> no beat advance until both high; total 10 write, 5 read.

Source files
------------

// File: rtl/tensor_controller_pkg.sv
// Shared encodings, FSM state type and sizing helpers for the tensor burst controller.
package tensor_controller_pkg;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_OPERATE = 2'b01;
  localparam logic [1:0] OP_BURST   = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  localparam logic [1:0] SEL_READ     = 2'b00;
  localparam logic [1:0] SEL_WRITE    = 2'b01;
  localparam logic [1:0] SEL_RW       = 2'b10;
  localparam logic [1:0] SEL_WRITE_M2 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPERATE = 2'd1,
    ST_BURST   = 2'd2
  } state_t;

  function automatic int calc_beats(input int elems, input int lanes);
    return (elems + lanes - 1) / lanes;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tensor_result_snapshot.sv
// Holds a copy of the core result for a read burst and slices it into LANES-wide beats,
// padding lanes past the last element with zero.
module tensor_result_snapshot
  import tensor_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ELEMS      = 9,
  parameter int LANES      = 2,
  parameter int BEAT_W     = 4
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic                        load_in,
  input  logic [ELEMS*DATA_WIDTH-1:0] result_in,
  input  logic [BEAT_W-1:0]           beat_in,
  output logic [LANES*DATA_WIDTH-1:0] beat_data_out
);

  localparam int BEATS = calc_beats(ELEMS, LANES);

  logic [ELEMS-1:0][DATA_WIDTH-1:0]       snap_q, snap_d;
  logic [BEATS*LANES-1:0][DATA_WIDTH-1:0] padded;

  always_comb begin
    snap_d = snap_q;
    if (load_in) snap_d = result_in;
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) snap_q <= '0;
    else           snap_q <= snap_d;
  end

  for (genvar e = 0; e < BEATS*LANES; e++) begin : g_pad
    if (e < ELEMS) begin : g_elem
      assign padded[e] = snap_q[e];
    end else begin : g_zero
      assign padded[e] = '0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_data;
    always_comb begin
      lane_data = '0;
      for (int b = 0; b < BEATS; b++)
        if (beat_in == BEAT_W'(b)) lane_data = padded[b*LANES + k];
    end
    assign beat_data_out[k*DATA_WIDTH +: DATA_WIDTH] = lane_data;
  end

endmodule

// File: rtl/tensor_burst_controller.sv
// Instruction decode, burst write/read sequencing and core start/done handling for the
// small tensor core; results stream out of a snapshot taken when a read burst is accepted.
module tensor_burst_controller
  import tensor_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 3,
  parameter int LANES      = 2
) (
  input  logic                                 clock_in,
  input  logic                                 reset_in,
  input  logic                                 instr_valid_in,
  output logic                                 instr_ready_out,
  input  logic [15:0]                          instr_in,
  input  logic                                 wr_valid_in,
  output logic                                 wr_ready_out,
  input  logic [LANES*DATA_WIDTH-1:0]          wr_data_in,
  output logic                                 rd_valid_out,
  input  logic                                 rd_ready_in,
  output logic [LANES*DATA_WIDTH-1:0]          rd_data_out,
  output logic                                 rf_we_out,
  output logic                                 rf_matrix_out,
  output logic [idx_width(DIM*DIM)-1:0]        rf_index_out,
  output logic [LANES-1:0]                     rf_lane_mask_out,
  output logic [LANES*DATA_WIDTH-1:0]          rf_data_out,
  output logic                                 core_start_out,
  output logic [1:0]                           core_op_out,
  input  logic                                 core_done_in,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]        core_result_in,
  output logic                                 busy_out,
  output logic                                 error_out
);

  localparam int ELEMS = DIM*DIM;
  localparam int BEATS = calc_beats(ELEMS, LANES);
  localparam int IDX_W = idx_width(ELEMS);
  localparam int CNT_W = idx_width(2*BEATS);
  localparam logic [CNT_W-1:0] BEATS_C  = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_ONE = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_TWO = CNT_W'(2*BEATS - 1);

  state_t                      state_q, state_d;
  logic [1:0]                  mode_q, mode_d;
  logic [CNT_W-1:0]            beat_q, beat_d;
  logic                        rd_valid_q, rd_valid_d;
  logic                        rf_we_q, rf_we_d;
  logic                        rf_matrix_q, rf_matrix_d;
  logic [IDX_W-1:0]            rf_index_q, rf_index_d;
  logic [LANES-1:0]            rf_mask_q, rf_mask_d;
  logic [LANES*DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic                        core_start_q, core_start_d;
  logic [1:0]                  core_op_q, core_op_d;
  logic                        error_q, error_d;

  logic [1:0]                  opcode, sel;
  logic                        instr_accept, in_burst, has_write, is_rw, paired;
  logic                        wr_fire, rd_fire, beat_fire, last_beat, snap_load;
  logic [CNT_W-1:0]            wr_slot;
  logic [LANES*DATA_WIDTH-1:0] snap_beat;
  logic                        unused_instr_bits;

  assign opcode            = instr_in[1:0];
  assign sel               = instr_in[3:2];
  assign unused_instr_bits = ^instr_in[15:4];

  assign instr_accept = instr_valid_in && (state_q == ST_IDLE);
  assign in_burst     = (state_q == ST_BURST);
  assign has_write    = (mode_q != SEL_READ);
  assign is_rw        = (mode_q == SEL_RW);
  assign paired       = is_rw && (beat_q < BEATS_C);

  // A paired READ_WRITE beat needs both sides at once, so write-ready waits on the reader.
  assign wr_ready_out = in_burst && has_write && (!paired || rd_ready_in);
  assign wr_fire      = wr_ready_out && wr_valid_in;
  assign rd_fire      = in_burst && rd_valid_q && rd_ready_in && (!is_rw || wr_valid_in);
  assign beat_fire    = has_write ? wr_fire : rd_fire;
  assign last_beat    = (mode_q == SEL_WRITE || is_rw) ? (beat_q == LAST_TWO)
                                                       : (beat_q == LAST_ONE);
  assign wr_slot      = (beat_q >= BEATS_C) ? (beat_q - BEATS_C) : beat_q;
  assign snap_load    = instr_accept && (opcode == OP_BURST) &&
                        ((sel == SEL_READ) || (sel == SEL_RW));

  tensor_result_snapshot #(
    .DATA_WIDTH (DATA_WIDTH),
    .ELEMS      (ELEMS),
    .LANES      (LANES),
    .BEAT_W     (CNT_W)
  ) u_snapshot (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .load_in       (snap_load),
    .result_in     (core_result_in),
    .beat_in       (beat_q),
    .beat_data_out (snap_beat)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    beat_d       = beat_q;
    rd_valid_d   = rd_valid_q;
    rf_we_d      = 1'b0;
    rf_matrix_d  = rf_matrix_q;
    rf_index_d   = rf_index_q;
    rf_mask_d    = rf_mask_q;
    rf_data_d    = rf_data_q;
    core_start_d = 1'b0;
    core_op_d    = core_op_q;
    error_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_accept) begin
          case (opcode)
            OP_OPERATE: begin
              state_d      = ST_OPERATE;
              core_start_d = 1'b1;
              core_op_d    = sel;
            end
            OP_BURST: begin
              state_d    = ST_BURST;
              mode_d     = sel;
              beat_d     = '0;
              rd_valid_d = (sel == SEL_READ) || (sel == SEL_RW);
            end
            OP_RSVD: error_d = 1'b1;
            default: ;
          endcase
        end
      end
      ST_OPERATE: begin
        if (core_done_in) state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (beat_fire) begin
          if (last_beat) begin
            state_d    = ST_IDLE;
            beat_d     = '0;
            rd_valid_d = 1'b0;
          end else begin
            beat_d = beat_q + 1'b1;
            if (beat_q == LAST_ONE) rd_valid_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_fire) begin
      rf_we_d     = 1'b1;
      rf_matrix_d = (mode_q == SEL_WRITE_M2) || (beat_q >= BEATS_C);
      rf_index_d  = IDX_W'(int'(wr_slot) * LANES);
      rf_data_d   = wr_data_in;
      for (int k = 0; k < LANES; k++)
        rf_mask_d[k] = (int'(wr_slot) * LANES + k) < ELEMS;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q      <= ST_IDLE;
      mode_q       <= SEL_READ;
      beat_q       <= '0;
      rd_valid_q   <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_matrix_q  <= 1'b0;
      rf_index_q   <= '0;
      rf_mask_q    <= '0;
      rf_data_q    <= '0;
      core_start_q <= 1'b0;
      core_op_q    <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      beat_q       <= beat_d;
      rd_valid_q   <= rd_valid_d;
      rf_we_q      <= rf_we_d;
      rf_matrix_q  <= rf_matrix_d;
      rf_index_q   <= rf_index_d;
      rf_mask_q    <= rf_mask_d;
      rf_data_q    <= rf_data_d;
      core_start_q <= core_start_d;
      core_op_q    <= core_op_d;
      error_q      <= error_d;
    end
  end

  assign instr_ready_out  = (state_q == ST_IDLE);
  assign busy_out         = (state_q != ST_IDLE);
  assign rd_valid_out     = rd_valid_q;
  assign rd_data_out      = {(LANES*DATA_WIDTH){rd_valid_q}} & snap_beat;
  assign rf_we_out        = rf_we_q;
  assign rf_matrix_out    = rf_matrix_q;
  assign rf_index_out     = rf_index_q;
  assign rf_lane_mask_out = rf_mask_q;
  assign rf_data_out      = rf_data_q;
  assign core_start_out   = core_start_q;
  assign core_op_out      = core_op_q;
  assign error_out        = error_q;

endmodule
